bet_recorder: RTL

BET_RECORDER -- requirements
Module: bet_recorder

---
 rtl/bet_pkg.sv | 39 +++
 rtl/key_edge_detect.sv | 32 +++
 rtl/bet_recorder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bet_pkg.sv
// Shared definitions for the roulette bet recorder: key opcodes, slot
// layout and FSM state encoding.
package bet_pkg;

  localparam int unsigned BET_W      = 8;
  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned COLOR_W    = 2;
  localparam int unsigned COLOR_IN_W = 3;
  localparam int unsigned COUNT_W    = 4;

  // Bit positions of the fields inside one 8-bit slot.
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned COLOR_LSB  = 6;

  localparam logic [OPCODE_W-1:0] OP_NONE   = 6'b111111;
  localparam logic [OPCODE_W-1:0] OP_SPIN   = 6'b111110;
  localparam logic [OPCODE_W-1:0] OP_CANCEL = 6'b111101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SPIN = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // One stored bet: {chip colour[1:0], position opcode}.
  typedef struct packed {
    logic [COLOR_W-1:0]  color;
    logic [OPCODE_W-1:0] opcode;
  } slot_t;

  function automatic slot_t make_slot(input logic [OPCODE_W-1:0]   op,
                                      input logic [COLOR_IN_W-1:0] col);
    slot_t s;
    s.color  = col[COLOR_W-1:0];
    s.opcode = op;
    return s;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Turns the level-type keyboard valid into a single-cycle keypress pulse.
// Ports: clock, reset (sync, active high), key_valid (level in),
//        rise_c (combinational one-cycle pulse on a rising edge).
module key_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic key_valid,
  output logic rise_c
);

  logic key_q, key_d;
  // Set when the key was already held while in reset; suppresses events
  // until the key has been released once.
  logic blocked_q, blocked_d;

  always_comb begin
    key_d     = key_valid;
    blocked_d = blocked_q & key_valid;
    rise_c    = key_valid & ~key_q & ~blocked_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      key_q     <= 1'b0;
      blocked_q <= key_valid;
    end else begin
      key_q     <= key_d;
      blocked_q <= blocked_d;
    end
  end

endmodule

// File: rtl/bet_recorder.sv
// Records roulette bets entered on the keyboard into a slot array, freezes
// them during the spin and holds them until the processor clears them.
// Ports: clock, reset (sync, active high); key_valid/bet_opcode/chip_color
//        keypress inputs; spin_done and clear pulses; bets (packed slots),
//        bet_count, full, spin_check, accept/reject pulses (all registered).
module bet_recorder
  import bet_pkg::*;
#(
  parameter int unsigned MAX_BETS = 12
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      key_valid,
  input  logic [OPCODE_W-1:0]       bet_opcode,
  input  logic [COLOR_IN_W-1:0]     chip_color,
  input  logic                      spin_done,
  input  logic                      clear,
  output logic [BET_W*MAX_BETS-1:0] bets,
  output logic [COUNT_W-1:0]        bet_count,
  output logic                      full,
  output logic                      spin_check,
  output logic                      accept,
  output logic                      reject
);

  state_e                     state_q, state_d;
  slot_t [MAX_BETS-1:0]       slots_q, slots_d;
  logic  [COUNT_W-1:0]        count_q, count_d;
  logic                       full_q, full_d;
  logic                       spin_q, spin_d;
  logic                       accept_q, accept_d;
  logic                       reject_q, reject_d;

  logic rise_c;
  logic key_event_c;
  logic is_spin_c;
  logic is_cancel_c;

  key_edge_detect u_edge (
    .clock     (clock),
    .reset     (reset),
    .key_valid (key_valid),
    .rise_c    (rise_c)
  );

  // Next-state, slot array and response pulses.
  always_comb begin
    state_d  = state_q;
    slots_d  = slots_q;
    count_d  = count_q;
    accept_d = 1'b0;
    reject_d = 1'b0;

    is_spin_c   = (bet_opcode == OP_SPIN);
    is_cancel_c = (bet_opcode == OP_CANCEL);
    key_event_c = rise_c && (bet_opcode != OP_NONE);

    case (state_q)
      ST_IDLE: begin
        // clear outranks a coincident keypress, which is dropped silently
        if (clear) begin
          slots_d = '0;
          count_d = '0;
        end else if (key_event_c) begin
          if (is_spin_c) begin
            if (count_q != '0) begin
              state_d  = ST_SPIN;
              accept_d = 1'b1;
            end else begin
              reject_d = 1'b1;
            end
          end else if (is_cancel_c) begin
            if (count_q != '0) begin
              for (int unsigned i = 0; i < MAX_BETS; i++) begin
                if (COUNT_W'(i) == count_q - COUNT_W'(1)) slots_d[i] = '0;
              end
              count_d  = count_q - COUNT_W'(1);
              accept_d = 1'b1;
            end else begin
              reject_d = 1'b1;
            end
          end else if ((chip_color != '0) && (count_q < COUNT_W'(MAX_BETS))) begin
            for (int unsigned i = 0; i < MAX_BETS; i++) begin
              if (COUNT_W'(i) == count_q) slots_d[i] = make_slot(bet_opcode, chip_color);
            end
            count_d  = count_q + COUNT_W'(1);
            accept_d = 1'b1;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      ST_SPIN: begin
        if (key_event_c) reject_d = 1'b1;
        if (spin_done)   state_d  = ST_HOLD;
      end
      ST_HOLD: begin
        if (key_event_c) reject_d = 1'b1;
        if (clear) begin
          slots_d = '0;
          count_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    full_d = (count_d == COUNT_W'(MAX_BETS));
    spin_d = (state_d == ST_SPIN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      slots_q  <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      spin_q   <= 1'b0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      slots_q  <= slots_d;
      count_q  <= count_d;
      full_q   <= full_d;
      spin_q   <= spin_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
    end
  end

  assign bets       = slots_q;
  assign bet_count  = count_q;
  assign full       = full_q;
  assign spin_check = spin_q;
  assign accept     = accept_q;
  assign reject     = reject_q;

endmodule
